// File: rtl/thermal_fan_ctrl_pkg.sv
// Shared types and defaults for the thermal fan controller.
//   fan_state_t : controller level, ordered so that a larger value means a faster fan
//   fan_speed_t : 2-bit fan drive code
//   speed_of()  : maps a level to its fan drive code (CRIT drives full speed)
package thermal_fan_ctrl_pkg;

  localparam int unsigned DEF_TEMP_W   = 8;
  localparam int unsigned DEF_AVG_LOG2 = 2;
  localparam int unsigned DEF_T_MED    = 60;
  localparam int unsigned DEF_T_MAX    = 80;
  localparam int unsigned DEF_T_CRIT   = 95;
  localparam int unsigned DEF_HYST     = 5;
  localparam int unsigned DEF_DWELL    = 64;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_LOW  = 3'd1,
    ST_MED  = 3'd2,
    ST_MAX  = 3'd3,
    ST_CRIT = 3'd4
  } fan_state_t;

  typedef logic [1:0] fan_speed_t;

  localparam fan_speed_t SPEED_OFF = 2'd0;
  localparam fan_speed_t SPEED_LOW = 2'd1;
  localparam fan_speed_t SPEED_MED = 2'd2;
  localparam fan_speed_t SPEED_MAX = 2'd3;

  function automatic fan_speed_t speed_of(input fan_state_t s);
    fan_speed_t sp;
    case (s)
      ST_OFF:  sp = SPEED_OFF;
      ST_LOW:  sp = SPEED_LOW;
      ST_MED:  sp = SPEED_MED;
      default: sp = SPEED_MAX;
    endcase
    return sp;
  endfunction

endpackage

// File: rtl/thermal_fan_ctrl_if.sv
// Sensors-side bundle of the fan controller.
//   in_use, temp_valid, temp        : sensors/system -> controller
//   fan_speed, throttle,
//   avg_temp, avg_valid             : controller -> sensors/power management
// master = sensors side, slave = controller.
interface thermal_fan_ctrl_if #(
  parameter int unsigned TEMP_W = 8
);
  import thermal_fan_ctrl_pkg::*;

  logic              in_use;
  logic              temp_valid;
  logic [TEMP_W-1:0] temp;
  fan_speed_t        fan_speed;
  logic              throttle;
  logic [TEMP_W-1:0] avg_temp;
  logic              avg_valid;

  modport master (
    output in_use, temp_valid, temp,
    input  fan_speed, throttle, avg_temp, avg_valid
  );

  modport slave (
    input  in_use, temp_valid, temp,
    output fan_speed, throttle, avg_temp, avg_valid
  );

endinterface

// File: rtl/thermal_fan_ctrl_temp_averager.sv
// Block averager: sums 2^AVG_LOG2 accepted samples and publishes the truncated mean.
//   CLK, nRST          : clock, async active-low reset
//   temp_valid, temp   : sample strobe and value
//   avg_temp           : last completed window average
//   avg_valid          : one-cycle pulse when avg_temp updates
module temp_averager #(
  parameter int unsigned TEMP_W   = 8,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  output logic [TEMP_W-1:0] avg_temp,
  output logic              avg_valid
);

  localparam int unsigned ACC_W = TEMP_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum_c;

  // Sum including the sample being accepted; ACC_W bits hold a full window.
  assign sum_c = acc + ACC_W'(temp);

  // Accumulate; on the last sample of a window publish the mean and restart.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc       <= '0;
      cnt       <= '0;
      avg_temp  <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (temp_valid) begin
        if (cnt == LAST_CNT) begin
          avg_temp  <= TEMP_W'(sum_c >> AVG_LOG2);
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum_c;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/thermal_fan_ctrl.sv
// Closed-loop fan controller: averages temperature, selects a fan level with
// hysteresis and a minimum dwell before downshifts, requests throttling in CRIT.
//   CLK, nRST : clock, async active-low reset
//   sens      : sensors bundle (slave side); see thermal_fan_ctrl_if
module thermal_fan_ctrl
  import thermal_fan_ctrl_pkg::*;
#(
  parameter int unsigned TEMP_W   = DEF_TEMP_W,
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
  parameter int unsigned T_MED    = DEF_T_MED,
  parameter int unsigned T_MAX    = DEF_T_MAX,
  parameter int unsigned T_CRIT   = DEF_T_CRIT,
  parameter int unsigned HYST     = DEF_HYST,
  parameter int unsigned DWELL    = DEF_DWELL
) (
  input logic             CLK,
  input logic             nRST,
  thermal_fan_ctrl_if.slave sens
);

  localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

  fan_state_t         state;
  fan_state_t         target_c;
  logic [DWELL_W-1:0] dwell;
  int unsigned        avg_c;
  int unsigned        thr_c;
  logic               down_ok_c;

  temp_averager #(
    .TEMP_W   (TEMP_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_averager (
    .CLK        (CLK),
    .nRST       (nRST),
    .temp_valid (sens.temp_valid),
    .temp       (sens.temp),
    .avg_temp   (sens.avg_temp),
    .avg_valid  (sens.avg_valid)
  );

  assign avg_c = 32'(sens.avg_temp);

  // Level the current average asks for.
  always_comb begin
    target_c = ST_OFF;
    if (avg_c >= T_CRIT)     target_c = ST_CRIT;
    else if (avg_c >= T_MAX) target_c = ST_MAX;
    else if (avg_c >= T_MED) target_c = ST_MED;
    else if (sens.in_use)    target_c = ST_LOW;
  end

  // Downshift gate: dwell expired and average clear of the current level's
  // threshold by HYST (written as avg+HYST < thr to avoid underflow). LOW uses
  // T_MED and may not drop to OFF while the system is busy.
  always_comb begin
    thr_c = T_MED;
    case (state)
      ST_CRIT: thr_c = T_CRIT;
      ST_MAX:  thr_c = T_MAX;
      default: thr_c = T_MED;
    endcase
    down_ok_c = (dwell == '0) && ((avg_c + HYST) < thr_c) &&
                !((state == ST_LOW) && sens.in_use);
  end

  // Level FSM, dwell counter and registered output decode.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= ST_OFF;
      dwell          <= '0;
      sens.fan_speed <= SPEED_OFF;
      sens.throttle  <= 1'b0;
    end else begin
      sens.fan_speed <= speed_of(state);
      sens.throttle  <= (state == ST_CRIT);
      if (sens.avg_valid && (target_c > state)) begin
        state <= target_c;
        dwell <= DWELL_LOAD;
      end else if (sens.avg_valid && (target_c < state) && down_ok_c) begin
        state <= fan_state_t'(state - 3'd1);
        dwell <= DWELL_LOAD;
      end else if ((state == ST_OFF) && sens.in_use) begin
        state <= ST_LOW;
        dwell <= DWELL_LOAD;
      end else if (dwell != '0) begin
        dwell <= dwell - DWELL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_thermal_fan_ctrl.sv
// Self-checking bench for thermal_fan_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural level model.
module tb_thermal_fan_ctrl;

  localparam int T_MED  = 60;
  localparam int T_MAX  = 80;
  localparam int T_CRIT = 95;
  localparam int HYST   = 5;
  localparam int DWELL  = 64;
  localparam int WIN    = 4;

  logic CLK;
  logic nRST;
  int   n_tests;
  int   n_fail;

  thermal_fan_ctrl_if #(.TEMP_W(8)) ifc ();

  thermal_fan_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .sens (ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  // Levels: 0 OFF, 1 LOW, 2 MED, 3 MAX, 4 CRIT. m_age counts edges since the
  // last level change; a downshift is allowed once DWELL-1 edges have passed.
  int m_sum, m_cnt, m_avg, m_avg_valid, m_lvl, m_age, m_speed, m_thr;

  function automatic int target_of(input int avg, input logic busy);
    if (avg >= T_CRIT) return 4;
    if (avg >= T_MAX)  return 3;
    if (avg >= T_MED)  return 2;
    return busy ? 1 : 0;
  endfunction

  function automatic int thr_of(input int lvl);
    if (lvl == 4) return T_CRIT;
    if (lvl == 3) return T_MAX;
    return T_MED;
  endfunction

  function automatic int next_level(input int lvl, input int av, input int avg,
                                    input logic busy, input int age);
    int nl;
    nl = lvl;
    if (av != 0) begin
      if (target_of(avg, busy) > lvl) nl = target_of(avg, busy);
      else if (target_of(avg, busy) < lvl && age >= DWELL - 1 &&
               avg + HYST < thr_of(lvl) && !(lvl == 1 && busy)) nl = lvl - 1;
    end
    if (nl == 0 && busy) nl = 1;
    return nl;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_sum <= 0; m_cnt <= 0; m_avg <= 0; m_avg_valid <= 0;
      m_lvl <= 0; m_age <= DWELL; m_speed <= 0; m_thr <= 0;
    end else begin
      m_lvl   <= next_level(m_lvl, m_avg_valid, m_avg, ifc.in_use, m_age);
      m_age   <= (next_level(m_lvl, m_avg_valid, m_avg, ifc.in_use, m_age) != m_lvl) ? 0 :
                 ((m_age < DWELL) ? m_age + 1 : m_age);
      m_speed <= (m_lvl > 3) ? 3 : m_lvl;
      m_thr   <= (m_lvl == 4) ? 1 : 0;
      m_avg_valid <= 0;
      if (ifc.temp_valid) begin
        if (m_cnt == WIN - 1) begin
          m_avg <= (m_sum + int'(ifc.temp)) / WIN;
          m_avg_valid <= 1;
          m_sum <= 0;
          m_cnt <= 0;
        end else begin
          m_sum <= m_sum + int'(ifc.temp);
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int t);
    ifc.temp_valid = 1'b1;
    ifc.temp       = 8'(t);
    @(negedge CLK);
    ifc.temp_valid = 1'b0;
  endtask

  task automatic send4(input int t);
    for (int i = 0; i < WIN; i++) send(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    nRST = 1'b0;
    ifc.in_use = 1'b0; ifc.temp_valid = 1'b0; ifc.temp = '0;
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd0) begin n_fail++; $display("FAIL reset_fan got=%0d exp=0", ifc.fan_speed); end
    n_tests++; if (ifc.throttle !== 1'b0) begin n_fail++; $display("FAIL reset_throttle got=%0b exp=0", ifc.throttle); end
    n_tests++; if (ifc.avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_avg_valid got=%0b exp=0", ifc.avg_valid); end
    n_tests++; if (ifc.avg_temp !== 8'd0) begin n_fail++; $display("FAIL reset_avg_temp got=%0d exp=0", ifc.avg_temp); end
    nRST = 1'b1;
    idle(3);
    n_tests++; if (ifc.fan_speed !== 2'd0) begin n_fail++; $display("FAIL idle_off got=%0d exp=0", ifc.fan_speed); end
  endtask

  task automatic test_in_use;
    ifc.in_use = 1'b1;
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd1) begin n_fail++; $display("FAIL in_use_low got=%0d exp=1", ifc.fan_speed); end
    send4(30);
    n_tests++; if (ifc.avg_valid !== 1'b1 || ifc.avg_temp !== 8'd30) begin n_fail++; $display("FAIL avg30 got=%0b/%0d exp=1/30", ifc.avg_valid, ifc.avg_temp); end
    idle(3);
    n_tests++; if (ifc.fan_speed !== 2'd1) begin n_fail++; $display("FAIL stay_low got=%0d exp=1", ifc.fan_speed); end
  endtask

  task automatic test_upshift;
    send4(70);
    n_tests++; if (ifc.avg_valid !== 1'b1 || ifc.avg_temp !== 8'd70) begin n_fail++; $display("FAIL avg70 got=%0b/%0d exp=1/70", ifc.avg_valid, ifc.avg_temp); end
    idle(1);
    n_tests++; if (ifc.avg_valid !== 1'b0) begin n_fail++; $display("FAIL avg_pulse_width got=%0b exp=0", ifc.avg_valid); end
    n_tests++; if (ifc.fan_speed !== 2'd1) begin n_fail++; $display("FAIL med_latency_early got=%0d exp=1", ifc.fan_speed); end
    idle(1);
    n_tests++; if (ifc.fan_speed !== 2'd2) begin n_fail++; $display("FAIL up_med got=%0d exp=2", ifc.fan_speed); end
    send4(90);
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd3) begin n_fail++; $display("FAIL up_max got=%0d exp=3", ifc.fan_speed); end
  endtask

  task automatic test_downshift;
    send4(57);
    idle(3);
    n_tests++; if (ifc.fan_speed !== 2'd3) begin n_fail++; $display("FAIL dwell_hold got=%0d exp=3", ifc.fan_speed); end
    idle(70);
    send4(57);
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd2) begin n_fail++; $display("FAIL down_med got=%0d exp=2", ifc.fan_speed); end
    send4(57);
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd2) begin n_fail++; $display("FAIL hyst_hold_med got=%0d exp=2", ifc.fan_speed); end
    idle(70);
    send4(50);
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd1) begin n_fail++; $display("FAIL down_low got=%0d exp=1", ifc.fan_speed); end
  endtask

  task automatic test_crit;
    send4(100);
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd3 || ifc.throttle !== 1'b1) begin n_fail++; $display("FAIL crit got=%0d/%0b exp=3/1", ifc.fan_speed, ifc.throttle); end
    idle(70);
    send4(92);
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd3 || ifc.throttle !== 1'b1) begin n_fail++; $display("FAIL crit_hold got=%0d/%0b exp=3/1", ifc.fan_speed, ifc.throttle); end
    send4(85);
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd3 || ifc.throttle !== 1'b0) begin n_fail++; $display("FAIL crit_to_max got=%0d/%0b exp=3/0", ifc.fan_speed, ifc.throttle); end
  endtask

  task automatic test_async_reset;
    // Controller is in MAX here; reset lands between clock edges.
    #2 nRST = 1'b0;
    #1;
    n_tests++; if (ifc.fan_speed !== 2'd0) begin n_fail++; $display("FAIL async_rst_fan got=%0d exp=0", ifc.fan_speed); end
    n_tests++; if (ifc.throttle !== 1'b0 || ifc.avg_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags got=%0b/%0b exp=0/0", ifc.throttle, ifc.avg_valid); end
    ifc.in_use = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    idle(3);
    n_tests++; if (ifc.fan_speed !== 2'd0) begin n_fail++; $display("FAIL post_rst_off got=%0d exp=0", ifc.fan_speed); end
  endtask

  task automatic test_back_to_back;
    send(255); send(255); send(255); send(254);
    n_tests++; if (ifc.avg_valid !== 1'b1 || ifc.avg_temp !== 8'd254) begin n_fail++; $display("FAIL avg_edge got=%0b/%0d exp=1/254", ifc.avg_valid, ifc.avg_temp); end
    // First sample of the next window is accepted during the avg_valid cycle.
    send(20); send(20); send(20);
    n_tests++; if (ifc.avg_valid !== 1'b0) begin n_fail++; $display("FAIL early_window got=%0b exp=0", ifc.avg_valid); end
    send(40);
    n_tests++; if (ifc.avg_valid !== 1'b1 || ifc.avg_temp !== 8'd25) begin n_fail++; $display("FAIL next_window got=%0b/%0d exp=1/25", ifc.avg_valid, ifc.avg_temp); end
    idle(2);
    n_tests++; if (ifc.fan_speed !== 2'd3 || ifc.throttle !== 1'b1) begin n_fail++; $display("FAIL edge_crit got=%0d/%0b exp=3/1", ifc.fan_speed, ifc.throttle); end
  endtask

  task automatic test_random;
    int base;
    int bases[6];
    bases = '{30, 57, 70, 85, 92, 100};
    @(negedge CLK);
    nRST = 1'b0;
    ifc.in_use = 1'b0; ifc.temp_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    base = 30;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      n_tests++;
      if (ifc.fan_speed !== 2'(m_speed) || ifc.throttle !== 1'(m_thr) ||
          ifc.avg_valid !== 1'(m_avg_valid) || ifc.avg_temp !== 8'(m_avg)) begin
        n_fail++;
        $display("FAIL random cyc=%0d got fan=%0d thr=%0b av=%0b avg=%0d exp fan=%0d thr=%0d av=%0d avg=%0d",
                 cyc, ifc.fan_speed, ifc.throttle, ifc.avg_valid, ifc.avg_temp,
                 m_speed, m_thr, m_avg_valid, m_avg);
      end
      if (cyc % 160 == 0) base = bases[$urandom_range(0, 5)];
      if ($urandom_range(0, 149) == 0) ifc.in_use = ~ifc.in_use;
      ifc.temp_valid = 1'($urandom_range(0, 1));
      ifc.temp       = 8'(base + $urandom_range(0, 10) - 5);
      @(negedge CLK);
    end
    ifc.temp_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_in_use();
    test_upshift();
    test_downshift();
    test_crit();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
